// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - controller state encoding
//   - default divide occupancy constant
//   - packed bundle of the stage load/flush enables plus canned values
// No ports; imported by pipe_ctrl and its interface users.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Default number of cycles a divide keeps the EX stage busy.
  localparam int DIV_CYCLES_DEFAULT = 33;

  // Divide counter width; holds any occupancy up to 255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DIV_BUSY  = 2'd1,
    ST_IRQ_FLUSH = 2'd2
  } state_e;

  // Load and flush enables for the PC and the four stage registers.
  typedef struct packed {
    logic ld_pc;
    logic ld_ifid;
    logic ld_idex;
    logic ld_exmem;
    logic ld_memwb;
    logic fl_ifid;
    logic fl_idex;
    logic fl_exmem;
  } stage_ctrl_t;

  // Normal flow: every register loads, nothing is flushed.
  localparam stage_ctrl_t CTRL_RUN    = '{ld_pc: 1'b1, ld_ifid: 1'b1, ld_idex: 1'b1,
                                          ld_exmem: 1'b1, ld_memwb: 1'b1,
                                          fl_ifid: 1'b0, fl_idex: 1'b0, fl_exmem: 1'b0};

  // Data bus stall: nothing moves anywhere.
  localparam stage_ctrl_t CTRL_FREEZE = '{default: 1'b0};

  // Divide in EX: front end and EX held, a bubble goes into MEM.
  localparam stage_ctrl_t CTRL_DIV    = '{ld_pc: 1'b0, ld_ifid: 1'b0, ld_idex: 1'b0,
                                          ld_exmem: 1'b1, ld_memwb: 1'b1,
                                          fl_ifid: 1'b0, fl_idex: 1'b0, fl_exmem: 1'b1};

  // Load-use hazard: PC and IF/ID hold, a bubble goes into EX.
  localparam stage_ctrl_t CTRL_LDUSE  = '{ld_pc: 1'b0, ld_ifid: 1'b0, ld_idex: 1'b1,
                                          ld_exmem: 1'b1, ld_memwb: 1'b1,
                                          fl_ifid: 1'b0, fl_idex: 1'b1, fl_exmem: 1'b0};

  // Taken jump from EX: kill the two younger instructions.
  localparam stage_ctrl_t CTRL_JUMP   = '{ld_pc: 1'b1, ld_ifid: 1'b1, ld_idex: 1'b1,
                                          ld_exmem: 1'b1, ld_memwb: 1'b1,
                                          fl_ifid: 1'b1, fl_idex: 1'b1, fl_exmem: 1'b0};

  // Interrupt entry: kill everything up to and including EX.
  localparam stage_ctrl_t CTRL_IRQ    = '{ld_pc: 1'b1, ld_ifid: 1'b1, ld_idex: 1'b1,
                                          ld_exmem: 1'b1, ld_memwb: 1'b1,
                                          fl_ifid: 1'b1, fl_idex: 1'b1, fl_exmem: 1'b1};

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Requests into the controller : bus_wait, jump_req/jump_addr, load_use,
//                                  div_start, irq_req/irq_vec
//   Controls out of the controller: ld_* and fl_* stage enables, redirect,
//                                  redir_addr, irq_ack, div_busy
// Modports: master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  bus_wait;
  logic                  jump_req;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  load_use;
  logic                  div_start;
  logic                  irq_req;
  logic [ADDR_WIDTH-1:0] irq_vec;

  logic                  ld_pc;
  logic                  ld_ifid;
  logic                  ld_idex;
  logic                  ld_exmem;
  logic                  ld_memwb;
  logic                  fl_ifid;
  logic                  fl_idex;
  logic                  fl_exmem;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redir_addr;
  logic                  irq_ack;
  logic                  div_busy;

  modport master (
    output bus_wait, jump_req, jump_addr, load_use, div_start, irq_req, irq_vec,
    input  ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb,
    input  fl_ifid, fl_idex, fl_exmem,
    input  redirect, redir_addr, irq_ack, div_busy
  );

  modport slave (
    input  bus_wait, jump_req, jump_addr, load_use, div_start, irq_req, irq_vec,
    output ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb,
    output fl_ifid, fl_idex, fl_exmem,
    output redirect, redir_addr, irq_ack, div_busy
  );

endinterface

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Central hazard/stall controller for a 5-stage pipeline. Decides every
// cycle which stage registers load, which get a bubble, and whether the PC
// is redirected (jump or interrupt). Also sequences multi-cycle divides.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pipe_ctrl_if.slave: requests in, stage controls out
// Parameters:
//   ADDR_WIDTH - instruction address width
//   DIV_CYCLES - EX occupancy of one divide, legal 2..255
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_ctrl_if.slave bus
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  stage_ctrl_t         ctrl;
  logic                redirect;
  logic [ADDR_WIDTH-1:0] redir_addr;
  logic                irq_ack;

  // Next-state and output decode. A bus stall overrides everything and
  // holds state and counter, so a stalled request is simply seen again on
  // the next unstalled cycle. In IDLE the request priority is
  // irq > jump > divide > load-use; a jump makes the dependent ID/IF
  // instructions irrelevant, which is why it masks load_use/div_start.
  // The divide counter is preloaded with DIV_CYCLES-1 on the start cycle,
  // so the start cycle plus the DIV_BUSY cycles add up to DIV_CYCLES.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl       = CTRL_RUN;
    redirect   = 1'b0;
    redir_addr = '0;
    irq_ack    = 1'b0;

    if (bus.bus_wait) begin
      ctrl = CTRL_FREEZE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.irq_req) begin
            ctrl       = CTRL_IRQ;
            redirect   = 1'b1;
            redir_addr = bus.irq_vec;
            irq_ack    = 1'b1;
            state_d    = ST_IRQ_FLUSH;
          end else if (bus.jump_req) begin
            ctrl       = CTRL_JUMP;
            redirect   = 1'b1;
            redir_addr = bus.jump_addr;
          end else if (bus.div_start) begin
            ctrl    = CTRL_DIV;
            cnt_d   = CNT_W'(DIV_CYCLES - 1);
            state_d = ST_DIV_BUSY;
          end else if (bus.load_use) begin
            ctrl = CTRL_LDUSE;
          end
        end

        ST_DIV_BUSY: begin
          if (cnt_q > CNT_W'(1)) begin
            ctrl  = CTRL_DIV;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end

        ST_IRQ_FLUSH: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and divide counter registers; reset abandons any divide or
  // interrupt entry in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive the interface from the decoded bundle.
  always_comb begin
    bus.ld_pc      = ctrl.ld_pc;
    bus.ld_ifid    = ctrl.ld_ifid;
    bus.ld_idex    = ctrl.ld_idex;
    bus.ld_exmem   = ctrl.ld_exmem;
    bus.ld_memwb   = ctrl.ld_memwb;
    bus.fl_ifid    = ctrl.fl_ifid;
    bus.fl_idex    = ctrl.fl_idex;
    bus.fl_exmem   = ctrl.fl_exmem;
    bus.redirect   = redirect;
    bus.redir_addr = redir_addr;
    bus.irq_ack    = irq_ack;
    bus.div_busy   = (state_q == ST_DIV_BUSY);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl with DIV_CYCLES = 4. A table of
// single-cycle vectors covers the IDLE/IRQ_FLUSH decode and bus stalls;
// hand-written sequences cover divide timing, interrupts held off by a
// divide, a stall in the middle of a divide, and reset mid-sequence.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int AW = 32;

  typedef struct {
    string       name;
    logic        bw;
    logic        jr;
    logic [31:0] ja;
    logic        lu;
    logic        ds;
    logic        ir;
    logic [31:0] iv;
    logic [4:0]  eLd;
    logic [2:0]  eFl;
    logic        eRed;
    logic [31:0] eAddr;
    logic        eAck;
    logic        eBusy;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[$];

  pipe_ctrl_if #(.ADDR_WIDTH(AW)) busIf ();

  pipe_ctrl #(.ADDR_WIDTH(AW), .DIV_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(string name, logic bw, logic jr, logic [31:0] ja,
                                 logic lu, logic ds, logic ir, logic [31:0] iv,
                                 logic [4:0] eLd, logic [2:0] eFl, logic eRed,
                                 logic [31:0] eAddr, logic eAck, logic eBusy);
    vec_t v;
    v.name = name; v.bw = bw; v.jr = jr; v.ja = ja; v.lu = lu; v.ds = ds;
    v.ir = ir; v.iv = iv; v.eLd = eLd; v.eFl = eFl; v.eRed = eRed;
    v.eAddr = eAddr; v.eAck = eAck; v.eBusy = eBusy;
    return v;
  endfunction

  // Drive one cycle of inputs just after a rising edge; outputs are then
  // sampled mid-cycle by checkOutput.
  task automatic applyStimulus(input logic bw, input logic jr, input logic [31:0] ja,
                               input logic lu, input logic ds, input logic ir,
                               input logic [31:0] iv);
    @(posedge clk);
    #1;
    busIf.bus_wait  = bw;
    busIf.jump_req  = jr;
    busIf.jump_addr = ja;
    busIf.load_use  = lu;
    busIf.div_start = ds;
    busIf.irq_req   = ir;
    busIf.irq_vec   = iv;
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [4:0] eLd, input logic [2:0] eFl,
                             input logic eRed, input logic [31:0] eAddr,
                             input logic eAck, input logic eBusy);
    logic [4:0]  aLd;
    logic [2:0]  aFl;
    logic [42:0] act;
    logic [42:0] exp;
    aLd = {busIf.ld_pc, busIf.ld_ifid, busIf.ld_idex, busIf.ld_exmem, busIf.ld_memwb};
    aFl = {busIf.fl_ifid, busIf.fl_idex, busIf.fl_exmem};
    act = {aLd, aFl, busIf.redirect, busIf.redir_addr, busIf.irq_ack, busIf.div_busy};
    exp = {eLd, eFl, eRed, eAddr, eAck, eBusy};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got ld=%b fl=%b red=%b addr=%h ack=%b busy=%b, want ld=%b fl=%b red=%b addr=%h ack=%b busy=%b",
               name, aLd, aFl, busIf.redirect, busIf.redir_addr, busIf.irq_ack, busIf.div_busy,
               eLd, eFl, eRed, eAddr, eAck, eBusy);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    busIf.bus_wait  = 1'b0;
    busIf.jump_req  = 1'b0;
    busIf.jump_addr = '0;
    busIf.load_use  = 1'b0;
    busIf.div_start = 1'b0;
    busIf.irq_req   = 1'b0;
    busIf.irq_vec   = '0;

    // Reset state, checked while reset is still asserted.
    repeat (2) @(posedge clk);
    #4;
    checkOutput("reset_defaults", 5'b11111, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // name, bw, jr, ja, lu, ds, ir, iv, eLd, eFl, eRed, eAddr, eAck, eBusy
    vecs.push_back(mkVec("idle_default",   0,0,32'h0,        0,0,0,32'h0,   5'b11111,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("load_use",       0,0,32'h0,        1,0,0,32'h0,   5'b00111,3'b010,0,32'h0,        0,0));
    vecs.push_back(mkVec("after_load_use", 0,0,32'h0,        0,0,0,32'h0,   5'b11111,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("jump_100",       0,1,32'h100,      0,0,0,32'h0,   5'b11111,3'b110,1,32'h100,      0,0));
    vecs.push_back(mkVec("jump_masks_div", 0,1,32'h200,      1,1,0,32'h0,   5'b11111,3'b110,1,32'h200,      0,0));
    vecs.push_back(mkVec("irq_over_jump",  0,1,32'h300,      0,0,1,32'h800, 5'b11111,3'b111,1,32'h800,      1,0));
    vecs.push_back(mkVec("irq_flush_cyc",  0,0,32'h0,        0,0,1,32'h800, 5'b11111,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("wait_blocks_irq",1,0,32'h0,        0,0,1,32'h900, 5'b00000,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("irq_after_wait", 0,0,32'h0,        0,0,1,32'h900, 5'b11111,3'b111,1,32'h900,      1,0));
    vecs.push_back(mkVec("wait_in_flush",  1,0,32'h0,        0,0,0,32'h0,   5'b00000,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("flush_resumes",  0,0,32'h0,        0,0,1,32'h900, 5'b11111,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("idle_again",     0,0,32'h0,        0,0,0,32'h0,   5'b11111,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("wait_blocks_jmp",1,1,32'hFFFFFFFC, 0,0,0,32'h0,   5'b00000,3'b000,0,32'h0,        0,0));
    vecs.push_back(mkVec("jump_top_addr",  0,1,32'hFFFFFFFC, 0,0,0,32'h0,   5'b11111,3'b110,1,32'hFFFFFFFC, 0,0));
    vecs.push_back(mkVec("wait_blocks_lu", 1,0,32'h0,        1,0,0,32'h0,   5'b00000,3'b000,0,32'h0,        0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].bw, vecs[i].jr, vecs[i].ja, vecs[i].lu, vecs[i].ds, vecs[i].ir, vecs[i].iv);
      checkOutput(vecs[i].name, vecs[i].eLd, vecs[i].eFl, vecs[i].eRed, vecs[i].eAddr,
                  vecs[i].eAck, vecs[i].eBusy);
    end

    // Divide of 4 cycles: start cycle plus three busy cycles.
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("div_start", 5'b00011, 3'b001, 0, 32'h0, 0, 0);
    idleCycle();
    checkOutput("div_busy1", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    idleCycle();
    checkOutput("div_busy2", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    idleCycle();
    checkOutput("div_last", 5'b11111, 3'b000, 0, 32'h0, 0, 1);
    idleCycle();
    checkOutput("div_done", 5'b11111, 3'b000, 0, 32'h0, 0, 0);

    // Interrupt raised during a divide waits for the divide to finish.
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("divirq_start", 5'b00011, 3'b001, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h800);
    checkOutput("divirq_busy1", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h800);
    checkOutput("divirq_busy2", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h800);
    checkOutput("divirq_last", 5'b11111, 3'b000, 0, 32'h0, 0, 1);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h800);
    checkOutput("divirq_taken", 5'b11111, 3'b111, 1, 32'h800, 1, 0);
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h800);
    checkOutput("divirq_flush", 5'b11111, 3'b000, 0, 32'h0, 0, 0);
    idleCycle();
    checkOutput("divirq_idle", 5'b11111, 3'b000, 0, 32'h0, 0, 0);

    // Bus stall of 5 cycles in the middle of a divide.
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0);
    checkOutput("divwait_start", 5'b00011, 3'b001, 0, 32'h0, 0, 0);
    idleCycle();
    checkOutput("divwait_busy1", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 32'h0, 0, 0, 0, 32'h0);
      checkOutput($sformatf("divwait_stall%0d", k), 5'b00000, 3'b000, 0, 32'h0, 0, 1);
    end
    idleCycle();
    checkOutput("divwait_busy2", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    idleCycle();
    checkOutput("divwait_last", 5'b11111, 3'b000, 0, 32'h0, 0, 1);
    idleCycle();
    checkOutput("divwait_done", 5'b11111, 3'b000, 0, 32'h0, 0, 0);

    // Reset in the middle of a divide.
    applyStimulus(0, 0, 32'h0, 0, 1, 0, 32'h0);
    idleCycle();
    checkOutput("divrst_busy", 5'b00011, 3'b001, 0, 32'h0, 0, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("divrst_in_reset", 5'b11111, 3'b000, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    checkOutput("divrst_after", 5'b11111, 3'b000, 0, 32'h0, 0, 0);

    // Reset during the interrupt flush cycle; no ack without a new request.
    applyStimulus(0, 0, 32'h0, 0, 0, 1, 32'h400);
    checkOutput("irqrst_taken", 5'b11111, 3'b111, 1, 32'h400, 1, 0);
    rst_n = 1'b0;
    busIf.irq_req = 1'b0;
    #1;
    checkOutput("irqrst_in_reset", 5'b11111, 3'b000, 0, 32'h0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycle();
    checkOutput("irqrst_after", 5'b11111, 3'b000, 0, 32'h0, 0, 0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0, 32'h0);
    checkOutput("irqrst_lu_ok", 5'b00111, 3'b010, 0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, instruction address width.
REQ-002 Parameter DIV_CYCLES, default 33, total EX-stage occupancy of one divide, legal range 2..255.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bus_wait  input  1  MEM-stage data bus not ready; freezes entire pipeline.
REQ-006 jump_req  input  1  EX-stage taken branch/jump this cycle.
REQ-007 jump_addr  input  ADDR_WIDTH  jump target, valid with jump_req.
REQ-008 load_use  input  1  ID-stage instruction depends on load in EX.
REQ-009 div_start  input  1  EX-stage divide instruction present, first cycle.
REQ-010 irq_req  input  1  level interrupt request from interrupt controller.
REQ-011 irq_vec  input  ADDR_WIDTH  interrupt vector, valid with irq_req.
REQ-012 ld_pc, ld_ifid, ld_idex, ld_exmem, ld_memwb  output  1 each  load enables for PC and stage registers.
REQ-013 fl_ifid, fl_idex, fl_exmem  output  1 each  synchronous flush (bubble insert) for stage registers.
REQ-014 redirect  output  1  PC takes redir_addr instead of sequential PC.
REQ-015 redir_addr  output  ADDR_WIDTH  redirect target.
REQ-016 irq_ack  output  1  one-cycle pulse, interrupt taken.
REQ-017 div_busy  output  1  divide sequence in progress.

Function
REQ-018 States: IDLE, DIV_BUSY, IRQ_FLUSH; outputs combinational from state and inputs.
REQ-019 Default (IDLE, no request): all ld_* = 1, all fl_* = 0, redirect = 0.
REQ-020 Priority, highest first: bus_wait, irq, jump, div_start, load_use.
REQ-021 bus_wait = 1: all ld_* = 0, fl_* = 0, redirect = 0, irq_ack = 0, state and counter frozen, in any state.
REQ-022 IDLE, irq_req = 1: fl_ifid = fl_idex = fl_exmem = 1, redirect = 1, redir_addr = irq_vec, irq_ack = 1, next state IRQ_FLUSH.
REQ-023 IRQ_FLUSH lasts exactly one cycle: all ld_* = 1, fl_* = 0, irq_req ignored, returns to IDLE.
REQ-024 IDLE, jump_req = 1 (no irq): fl_ifid = fl_idex = 1, redirect = 1, redir_addr = jump_addr; load_use and div_start ignored.
REQ-025 IDLE, div_start = 1: counter loaded with DIV_CYCLES-1, div_busy = 1, next state DIV_BUSY; ld_pc = ld_ifid = ld_idex = 0, fl_exmem = 1.
REQ-026 DIV_BUSY: counter decrements each non-frozen cycle; same hold/bubble as REQ-025 while counter > 1; at counter = 1 all ld_* = 1, fl_* = 0, return to IDLE, div_busy = 0 next cycle.
REQ-027 Divide occupies EX for exactly DIV_CYCLES unfrozen cycles including the div_start cycle.
REQ-028 IDLE, load_use = 1 only: ld_pc = ld_ifid = 0, fl_idex = 1, ld_exmem = ld_memwb = 1.
REQ-029 irq_req and jump_req in DIV_BUSY: not serviced; irq remains pending until IDLE (level held by source); jump_req cannot occur (EX held).
REQ-030 irq and jump same cycle: irq wins, redir_addr = irq_vec, jump discarded (flushed).
REQ-031 redir_addr = 0 when redirect = 0.

Reset
REQ-032 rst_n low: state = IDLE, counter = 0, div_busy = 0; outputs follow IDLE defaults (irq_ack = 0, redirect = 0).
REQ-033 Reset mid-divide or mid-IRQ_FLUSH abandons sequence; no irq_ack after reset release without new irq_req.

Structure
REQ-034 State encoding and default DIV_CYCLES constant reside in shared defines file.
REQ-035 Single module, no sub-modules; stage registers are external loadable flops driven by ld_*/fl_*.

Verification
REQ-036 load_use = 1 one cycle in IDLE -> ld_pc = ld_ifid = 0, fl_idex = 1, then defaults next cycle.
REQ-037 jump_req = 1, jump_addr = 0x0000_0100 -> redirect = 1, redir_addr = 0x100, fl_ifid = fl_idex = 1, one cycle.
REQ-038 div_start with DIV_CYCLES = 4 -> div_busy high 3 cycles after start, ld_pc low 3 cycles, all loads high on 4th cycle.
REQ-039 irq_req during DIV_BUSY with irq_vec = 0x0000_0800 -> no ack until divide ends, then irq_ack pulse, redir_addr = 0x800, three flushes.
REQ-040 bus_wait held 5 cycles mid-divide -> all ld_* = 0, counter frozen, divide completes 5 cycles late.
REQ-041 rst_n low during DIV_BUSY -> next cycle IDLE defaults, div_busy = 0.
